// File: rtl/sha256_digest_reader.sv
// sha256_digest_reader: captures the final H0..H7 hash state and streams it as NUM_WORDS words over valid/ready, H0 first; ports CLK, RST (sync active-high), digest_valid_i, digest_i, ready_i, data_o, valid_o, last_o, busy_o, overrun_o; define SHA256_DIGEST_BSWAP_EN to byte-reverse each output word
module sha256_digest_reader #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        digest_valid_i,
  input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
  input  logic                        ready_i,
  output logic [WORD_W-1:0]           data_o,
  output logic                        valid_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        overrun_o
);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [WORD_W*NUM_WORDS-1:0] dbuf, dbuf_n;
  logic [WORD_W-1:0] words [NUM_WORDS];
  logic [WORD_W-1:0] wsel, data_n;
  logic xfer, done, cap, valid_n, last_n, ovr_n;
  always_comb begin
    xfer    = valid_o & ready_i;
    done    = xfer && idx == LAST;
    // a pulse coinciding with the final beat is a legal back-to-back capture
    cap     = digest_valid_i && (state == IDLE || done);
    ovr_n   = digest_valid_i && !cap;
    state_n = cap ? SEND : done ? IDLE : state;
    idx_n   = cap ? '0 : (xfer && !done) ? idx + 1'b1 : idx;
    dbuf_n  = cap ? digest_i : dbuf;
    for (int i = 0; i < NUM_WORDS; i++) words[i] = dbuf_n[WORD_W*(NUM_WORDS-1-i) +: WORD_W];
    wsel    = words[idx_n];
    data_n  = wsel;
`ifdef SHA256_DIGEST_BSWAP_EN
    for (int b = 0; b < WORD_W/8; b++) data_n[8*b +: 8] = wsel[WORD_W-8-8*b +: 8];
`endif
    valid_n = state_n == SEND;
    last_n  = valid_n && idx_n == LAST;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      dbuf      <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      dbuf      <= dbuf_n;
      data_o    <= valid_n ? data_n : data_o;
      valid_o   <= valid_n;
      last_o    <= last_n;
      busy_o    <= valid_n;
      overrun_o <= ovr_n;
    end
  end
endmodule

// File: doc/sha256_digest_reader.md
Name: sha256_digest_reader

Overview:
- Reads the final 256-bit SHA-256 hash state (H0..H7) once the compression core signals completion.
- Streams the digest out as eight 32-bit words over a valid/ready handshake, H0 first.
- Sits between the hash-state registers and the host/output interface; it is the read side of the hash-register load path.

Parameters:
- WORD_W, 32, width of each output word and of each hash-state word
- NUM_WORDS, 8, number of words per digest (H0..H7)

Ports:
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- digest_valid_i  input  1  one-cycle pulse: digest_i holds a completed hash
- digest_i  input  WORD_W*NUM_WORDS  H0 in [255:224] … H7 in [31:0]
- ready_i  input  1  downstream accepts data_o this cycle
- data_o  output  WORD_W  current output word
- valid_o  output  1  data_o is valid
- last_o  output  1  data_o is the final word (H7)
- busy_o  output  1  a digest is held and not yet fully transferred
- overrun_o  output  1  one-cycle pulse: digest_valid_i was dropped because the block was busy

Behaviour:
- Reset:
  - Synchronous and active-high, sampled on the CLK rising edge.
  - On RST=1 at an edge, the next state is: state=IDLE, word index=0, capture buffer=0, data_o=0, valid_o=0, last_o=0, busy_o=0, overrun_o=0.
  - Reset has priority over every other input.
  - Reset mid-stream abandons the digest; no further words are emitted.
- All outputs are registered.
- FSM states: IDLE and SEND.
- IDLE:
  - digest_valid_i=1 captures digest_i into the internal buffer, sets idx=0 and moves to SEND.
  - valid_o=1 and busy_o=1 from the next cycle, i.e. latency 1 cycle from pulse to first valid word.
- SEND:
  - data_o = buffered word idx.
  - last_o = (idx == NUM_WORDS-1).
  - A beat transfers when valid_o & ready_i at a rising edge.
  - On a transfer with idx < NUM_WORDS-1: idx increments and data_o updates next cycle.
  - On a transfer with idx = NUM_WORDS-1: go to IDLE; valid_o, last_o and busy_o drop next cycle; data_o holds its last value.
- Handshake rules:
  - While valid_o=1 and ready_i=0, data_o, last_o and idx are held stable.
  - valid_o never drops before a transfer except on reset.
  - ready_i is ignored when valid_o=0.
- Simultaneous events:
  - digest_valid_i=1 in the same cycle as the final beat's transfer: the new digest is captured and the block stays in SEND with idx=0. valid_o stays high with no bubble (back-to-back digests). No overrun.
  - digest_valid_i=1 in SEND at any other time: the pulse is ignored, the buffer is unchanged, and overrun_o pulses high for exactly one cycle (the next cycle).
- Index counter:
  - Width is clog2(NUM_WORDS).
  - It never wraps internally; return to 0 happens only through the end-of-digest transition or a new capture.
- digest_i is sampled only on an accepted digest_valid_i; at all other times it is don't-care.

Optional Feature:
- Macro: SHA256_DIGEST_BSWAP_EN.
- When defined: each output word is byte-reversed, e.g. H0=32'hBA7816BF is emitted as 32'hBF1678BA, for little-endian hosts. Timing and handshake are unchanged.
- When undefined: words are emitted big-endian, exactly as held in the hash state.

Test Plan:
- Digest of "abc" (ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad) with ready_i held 1 -> valid_o rises 1 cycle after the pulse; eight consecutive words in that order; last_o=1 only with f20015ad; busy_o low the cycle after.
- Same digest with ready_i toggling 1,0,0,1,… -> data_o and last_o stable through every stall; same 8-word sequence; no duplicated or lost words.
- Second digest_valid_i (digest_i=all 32'h11111111) during word 3 -> overrun_o high for exactly 1 cycle; output remains the "abc" words.
- Second digest pulse coincident with the H7 transfer -> next cycle valid_o=1, data_o=32'h11111111, idx 0, overrun_o=0.
- RST=1 while streaming word 5 -> next cycle valid_o=0, busy_o=0, data_o=0; a subsequent pulse restarts at H0.
- With SHA256_DIGEST_BSWAP_EN defined, "abc" digest -> first word 32'hBF1678BA, last word 32'hAD1500F2.
